reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard.sv | 105 ++++++++++
 tb/tb_reg_scoreboard.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: counts in-flight writes per architectural
// register and derives RAW hazard / issue gating from that registered state.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_wb_en,
    input  logic [$clog2(NREG)-1:0] issue_dest,
    input  logic [$clog2(NREG)-1:0] src1,
    input  logic [$clog2(NREG)-1:0] src2,
    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_dest,
    output logic                    hazard_detected,
    output logic                    issue_ready,
    output logic                    issue_fire,
    output logic                    pending_any,
    output logic                    err_underflow
);

    localparam int IW = $clog2(NREG);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // Entry 0 of the view is hard-wired to zero so r0 never reports pending.
    logic [CW-1:0]   cnt_view [NREG];
    logic [NREG-1:0] nonzero_vec;
    logic [NREG-1:0] underflow_vec;

    logic inc;
    logic dec;
    logic full;
    logic haz1;
    logic haz2;
    logic err_q;
    logic err_d;

    assign cnt_view[0]      = '0;
    assign nonzero_vec[0]   = 1'b0;
    assign underflow_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            localparam logic [IW-1:0] IDX = IW'(gi);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          inc_hit;
            logic          dec_hit;

            assign inc_hit = inc && (issue_dest == IDX);
            assign dec_hit = dec && (wb_dest == IDX);

            always_comb begin
                cnt_d = cnt_q;
                if (inc_hit && !dec_hit) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (dec_hit && !inc_hit && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            // A simultaneous issue and write-back cancel, even on a zero counter.
            assign underflow_vec[gi] = dec_hit && !inc_hit && (cnt_q == '0);
            assign nonzero_vec[gi]   = (cnt_q != '0);
            assign cnt_view[gi]      = cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign haz1            = (src1 != '0) && (cnt_view[src1] != '0);
    assign haz2            = (src2 != '0) && (cnt_view[src2] != '0);
    assign hazard_detected = haz1 || haz2;

    // Blocking at the saturation value guarantees counters never wrap.
    assign full        = issue_wb_en && (issue_dest != '0) && (cnt_view[issue_dest] == CNT_MAX);
    assign issue_ready = !hazard_detected && !full;
    assign issue_fire  = issue_valid && issue_ready;

    assign inc = issue_fire && issue_wb_en && (issue_dest != '0);
    assign dec = wb_valid && (wb_dest != '0);

    assign pending_any = |nonzero_vec;

    assign err_d = err_q || (|underflow_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each task drives one scenario and checks
// the combinational outputs against hand-derived expectations.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_wb_en;
    logic [4:0] issue_dest;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       wb_valid;
    logic [4:0] wb_dest;
    logic       hazard_detected;
    logic       issue_ready;
    logic       issue_fire;
    logic       pending_any;
    logic       err_underflow;

    int n_checks;
    int n_fail;

    reg_scoreboard #(.NREG(32), .CW(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_wb_en    (issue_wb_en),
        .issue_dest     (issue_dest),
        .src1           (src1),
        .src2           (src2),
        .wb_valid       (wb_valid),
        .wb_dest        (wb_dest),
        .hazard_detected(hazard_detected),
        .issue_ready    (issue_ready),
        .issue_fire     (issue_fire),
        .pending_any    (pending_any),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 1'b0;
        issue_wb_en = 1'b0;
        issue_dest  = 5'd0;
        src1        = 5'd0;
        src2        = 5'd0;
        wb_valid    = 1'b0;
        wb_dest     = 5'd0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [4:0] dest, input logic [4:0] s1, input logic [4:0] s2);
        issue_valid = 1'b1;
        issue_wb_en = 1'b1;
        issue_dest  = dest;
        src1        = s1;
        src2        = s2;
    endtask

    task automatic drive_wb(input logic [4:0] dest);
        wb_valid = 1'b1;
        wb_dest  = dest;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'($urandom);
            issue_wb_en = 1'($urandom);
            issue_dest  = 5'($urandom);
            src1        = 5'($urandom);
            src2        = 5'($urandom);
            wb_valid    = 1'($urandom);
            wb_dest     = 5'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        for (int r = 1; r < 32; r++) begin
            src1 = 5'(r);
            #1;
            n_checks++;
            if (hazard_detected !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_cnt_zero r=%0d hazard=%b expected 0", r, hazard_detected);
            end
        end
        src1 = 5'd0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_issue_ready got=%b expected 1", issue_ready);
        end
        n_checks++;
        if (pending_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending_any got=%b expected 0", pending_any);
        end
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err_underflow got=%b expected 0", err_underflow);
        end
        $display("test_reset done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_raw_stall();
        idle();
        drive_issue(5'd5, 5'd1, 5'd2);
        #1;
        n_checks++;
        if (issue_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_first_issue fire=%b expected 1", issue_fire);
        end
        tick();
        idle();
        issue_valid = 1'b1;
        src1        = 5'd5;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1 || issue_fire !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_stall hazard=%b fire=%b expected 1/0", hazard_detected, issue_fire);
        end
        drive_wb(5'd5);
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_wb_same_cycle hazard=%b expected 1", hazard_detected);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || issue_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_release hazard=%b fire=%b expected 0/1", hazard_detected, issue_fire);
        end
        idle();
        tick();
        n_checks++;
        if (pending_any !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_drained pending=%b err=%b expected 0/0", pending_any, err_underflow);
        end
        $display("test_raw_stall done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_saturation();
        idle();
        for (int k = 0; k < 3; k++) begin
            drive_issue(5'd7, 5'd1, 5'd2);
            #1;
            n_checks++;
            if (issue_fire !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_issue_%0d fire=%b expected 1", k, issue_fire);
            end
            tick();
        end
        drive_issue(5'd7, 5'd1, 5'd2);
        #1;
        n_checks++;
        if (issue_ready !== 1'b0 || issue_fire !== 1'b0 || hazard_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_full ready=%b fire=%b hazard=%b expected 0/0/0",
                     issue_ready, issue_fire, hazard_detected);
        end
        tick();
        idle();
        drive_wb(5'd7);
        tick();
        idle();
        drive_issue(5'd7, 5'd1, 5'd2);
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ready_after_wb ready=%b expected 1", issue_ready);
        end
        // Counter is now 2: two more write-backs must drain it with no underflow.
        idle();
        drive_wb(5'd7);
        tick();
        src1 = 5'd7;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_cnt1_pending hazard=%b expected 1", hazard_detected);
        end
        tick();
        idle();
        src1 = 5'd7;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_drained hazard=%b err=%b expected 0/0", hazard_detected, err_underflow);
        end
        idle();
        $display("test_saturation done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_simultaneous();
        idle();
        drive_issue(5'd9, 5'd0, 5'd0);
        tick();
        drive_issue(5'd9, 5'd0, 5'd0);
        drive_wb(5'd9);
        #1;
        n_checks++;
        if (issue_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_fire fire=%b expected 1", issue_fire);
        end
        tick();
        idle();
        src2 = 5'd9;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_cnt_held hazard=%b expected 1", hazard_detected);
        end
        idle();
        drive_wb(5'd9);
        tick();
        idle();
        src2 = 5'd9;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_cnt_one hazard=%b expected 0", hazard_detected);
        end
        drive_issue(5'd9, 5'd0, 5'd0);
        drive_wb(5'd9);
        tick();
        idle();
        src2 = 5'd9;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_zero hazard=%b err=%b expected 0/0", hazard_detected, err_underflow);
        end
        idle();
        $display("test_simultaneous done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_r0_underflow();
        idle();
        drive_issue(5'd0, 5'd0, 5'd0);
        drive_wb(5'd0);
        tick();
        idle();
        issue_valid = 1'b1;
        #1;
        n_checks++;
        if (hazard_detected !== 1'b0 || pending_any !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_ignored hazard=%b pending=%b err=%b expected 0/0/0",
                     hazard_detected, pending_any, err_underflow);
        end
        idle();
        drive_wb(5'd12);
        #1;
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_not_early err=%b expected 0", err_underflow);
        end
        tick();
        idle();
        n_checks++;
        if (err_underflow !== 1'b1 || pending_any !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_set err=%b pending=%b expected 1/0", err_underflow, pending_any);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky err=%b expected 1", err_underflow);
        end
        $display("test_r0_underflow done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        drive_issue(5'd3, 5'd0, 5'd0);
        tick();
        drive_issue(5'd3, 5'd0, 5'd0);
        tick();
        drive_issue(5'd4, 5'd0, 5'd0);
        tick();
        idle();
        src1 = 5'd3;
        src2 = 5'd4;
        #1;
        n_checks++;
        if (pending_any !== 1'b1 || hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre pending=%b hazard=%b expected 1/1", pending_any, hazard_detected);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (pending_any !== 1'b0 || hazard_detected !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_cleared pending=%b hazard=%b err=%b expected 0/0/0",
                     pending_any, hazard_detected, err_underflow);
        end
        idle();
        drive_wb(5'd3);
        tick();
        idle();
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_stale_wb err=%b expected 1", err_underflow);
        end
        $display("test_mid_reset done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        #2;
        test_reset();
        test_raw_stall();
        test_saturation();
        test_simultaneous();
        test_r0_underflow();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
